pong_ctrl: RTL
==============

Name: pong_ctrl

Overview:
- Frame-rate game sequencer for the 640x480 DVI drawing path.
- Once per frame, during vertical blanking, it updates ball and paddle positions, handles bounces, paddle hits and misses, and runs a serve/play/miss state machine.
- It also produces registered per-pixel draw flags from the display timing coordinates. These feed the colour mux ahead of the DVI output registers.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- BALL_SIZE, 8, ball edge length (pixels)
- PADDLE_X, 16, paddle left column
- PADDLE_W, 8, paddle width
- PADDLE_H, 64, paddle height
- BALL_SPEED, 2, ball step per frame on each axis
- PADDLE_SPEED, 4, paddle step per frame
- SERVE_FRAMES, 60, frames waited in SERVE before automatic launch

Ports:
- pix_clk  in  1  pixel clock
- rst_pix_n  in  1  asynchronous active-low reset
- sx  in  10  horizontal position from the display signal generator; active area is 0..H_RES-1
- sy  in  10  vertical position; active area is 0..V_RES-1
- btn_up  in  1  asynchronous button, move paddle up
- btn_dn  in  1  asynchronous button, move paddle down
- btn_serve  in  1  asynchronous button, launch ball early
- ball_x  out  10  ball left column
- ball_y  out  10  ball top row
- paddle_y  out  10  paddle top row
- draw_ball  out  1  current pixel is inside the ball
- draw_paddle  out  1  current pixel is inside the paddle
- miss_count  out  8  misses since reset, saturating
- playing  out  1  FSM is in PLAY

Behaviour:
- Clock and reset: one clock, pix_clk. rst_pix_n is asynchronous active-low; assertion takes effect immediately, release is synchronous to pix_clk.
- Reset values:
  - ball_x=(H_RES-BALL_SIZE)/2=316, ball_y=(V_RES-BALL_SIZE)/2=236.
  - paddle_y=(V_RES-PADDLE_H)/2=208.
  - draw_ball=0, draw_paddle=0, miss_count=0, playing=0.
  - FSM in SERVE, serve counter=0, dir_x=left, dir_y=down.
- Button inputs: each passes through a 2-flop synchronizer. Buttons are sampled only at frame_tick, so no debounce is required.
- frame_tick: internal single-cycle registered pulse, set for the cycle after sx==0 && sy==V_RES. It fires exactly once per frame, inside vertical blanking.
- All position and FSM updates happen only on frame_tick.
- Paddle update (every tick, in all states):
  - up only: paddle_y = max(paddle_y-PADDLE_SPEED, 0).
  - down only: paddle_y = min(paddle_y+PADDLE_SPEED, V_RES-PADDLE_H).
  - both or neither: hold.
- FSM states:
  - SERVE: ball held at centre, dir_x=left. Counter increments per tick. Go to PLAY when counter==SERVE_FRAMES-1 or synced btn_serve=1 at a tick; clear the counter on exit.
  - PLAY: ball moves per the rules below. On a miss, go to MISS.
  - MISS: miss_count += 1 unless it is already 255. The next tick goes to SERVE and re-centres the ball.
- Ball X, moving right:
  - If ball_x+BALL_SPEED >= H_RES-BALL_SIZE: ball_x=H_RES-BALL_SIZE (632), dir_x=left.
  - Else ball_x += BALL_SPEED.
- Ball X, moving left (evaluated in this order):
  1. If ball_x >= PADDLE_X+PADDLE_W+BALL_SPEED: ball_x -= BALL_SPEED.
  2. Else if ball_x >= PADDLE_X+PADDLE_W and vertical overlap holds: ball_x=PADDLE_X+PADDLE_W (24), dir_x=right. Vertical overlap is ball_y+BALL_SIZE > paddle_y && ball_y < paddle_y+PADDLE_H, using the pre-update paddle_y.
  3. Else if ball_x < BALL_SPEED: miss; ball_x is held.
  4. Else ball_x -= BALL_SPEED. The ball has passed the paddle face and continues to the wall.
- Ball Y:
  - Moving down: if ball_y+BALL_SPEED >= V_RES-BALL_SIZE, then ball_y=472 and dir_y=up; else ball_y += BALL_SPEED.
  - Moving up: if ball_y <= BALL_SPEED, then ball_y=0 and dir_y=down; else ball_y -= BALL_SPEED.
  - The X and Y updates are independent and happen in the same tick. A corner hit therefore flips both directions.
- Arithmetic: all compares use 11-bit unsigned values so sums cannot wrap. Positions never leave the ranges ball_x 0..632, ball_y 0..472, paddle_y 0..416.
- Draw flags: registered, 1-cycle latency relative to sx/sy.
  - draw_ball = sx in [ball_x, ball_x+BALL_SIZE) && sy in [ball_y, ball_y+BALL_SIZE) && sx<H_RES && sy<V_RES.
  - draw_paddle: same form using PADDLE_X/PADDLE_W and paddle_y/PADDLE_H.
  - Because positions change only in blanking, no tearing occurs within a frame.
- Reset mid-frame or mid-play: all state returns to reset values immediately. The first tick after release behaves as SERVE tick 0.

Test Plan:
- Reset and serve: reset, run 60 frames with no buttons -> ball stays (316,236) and playing=0 through tick 59; playing=1 after tick 59; first PLAY tick gives ball (314,238).
- Early serve and wall bounce: btn_serve at the first tick -> PLAY. Force a state with ball_y=471 moving down -> next tick ball_y=472 and dir_y=up; following tick ball_y=470.
- Paddle hit: paddle_y=208, ball at (25,230) moving left -> tick gives ball_x=24, dir_x=right; next tick ball_x=26.
- Miss: paddle_y=0, ball at (1,300) moving left -> MISS, next tick SERVE, miss_count=1, ball re-centred at (316,236). Force miss_count=255 then another miss -> stays 255.
- Paddle clamp: hold btn_up from paddle_y=208 for 60 frames -> reaches 0 and holds. Hold both buttons -> no change. Hold btn_dn -> stops at 416.
- Draw flags and reset: sweep sx/sy with ball at (316,236) -> draw_ball high exactly for sx 316..323, sy 236..243, one cycle after the matching coordinates. Assert rst_pix_n mid-line -> all outputs take reset values without a clock edge.

Source files
------------

// File: rtl/pong_ctrl.sv
// Frame-rate game sequencer for the 640x480 drawing path: ball/paddle motion,
// serve/play/miss sequencing on each vertical-blanking tick, and registered draw flags.
module pong_ctrl #(
  parameter int unsigned H_RES        = 640,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_X     = 16,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned BALL_SPEED   = 2,
  parameter int unsigned PADDLE_SPEED = 4,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       pix_clk,
  input  logic       rst_pix_n,
  input  logic [9:0] sx,
  input  logic [9:0] sy,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       btn_serve,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_y,
  output logic       draw_ball,
  output logic       draw_paddle,
  output logic [7:0] miss_count,
  output logic       playing
);

  localparam int unsigned PW    = 10;
  localparam int unsigned AW    = 11;
  localparam int unsigned CNT_W = $clog2(SERVE_FRAMES);

  localparam logic [AW-1:0] X_MAX  = AW'(H_RES - BALL_SIZE);
  localparam logic [AW-1:0] Y_MAX  = AW'(V_RES - BALL_SIZE);
  localparam logic [AW-1:0] PY_MAX = AW'(V_RES - PADDLE_H);
  localparam logic [AW-1:0] FACE   = AW'(PADDLE_X + PADDLE_W);
  localparam logic [AW-1:0] B_SPD  = AW'(BALL_SPEED);
  localparam logic [AW-1:0] P_SPD  = AW'(PADDLE_SPEED);
  localparam logic [AW-1:0] B_SZ   = AW'(BALL_SIZE);
  localparam logic [AW-1:0] P_H    = AW'(PADDLE_H);
  localparam logic [AW-1:0] P_X    = AW'(PADDLE_X);
  localparam logic [AW-1:0] HR     = AW'(H_RES);
  localparam logic [AW-1:0] VR     = AW'(V_RES);

  localparam logic [PW-1:0] BX0 = PW'((H_RES - BALL_SIZE) / 2);
  localparam logic [PW-1:0] BY0 = PW'((V_RES - BALL_SIZE) / 2);
  localparam logic [PW-1:0] PY0 = PW'((V_RES - PADDLE_H) / 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {ST_SERVE, ST_PLAY, ST_MISS} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  serve_cnt, cnt_nxt;
  logic              dir_x, dir_y, dir_x_nxt, dir_y_nxt;  // dir_x 1 = right, dir_y 1 = down
  logic [PW-1:0]     bx_nxt, by_nxt, py_nxt;
  logic [7:0]        miss_nxt;
  logic [1:0]        up_sync, dn_sync, srv_sync;
  logic              frame_tick;
  logic [AW-1:0]     bx, by, py, sx_w, sy_w;
  logic              overlap_c, in_ball_c, in_paddle_c;

  assign bx   = AW'(ball_x);
  assign by   = AW'(ball_y);
  assign py   = AW'(paddle_y);
  assign sx_w = AW'(sx);
  assign sy_w = AW'(sy);

  assign overlap_c   = (by + B_SZ > py) && (by < py + P_H);
  assign in_ball_c   = (sx_w >= bx) && (sx_w < bx + B_SZ) && (sy_w >= by) && (sy_w < by + B_SZ)
                       && (sx_w < HR) && (sy_w < VR);
  assign in_paddle_c = (sx_w >= P_X) && (sx_w < FACE) && (sy_w >= py) && (sy_w < py + P_H)
                       && (sx_w < HR) && (sy_w < VR);

  // Next-state logic: everything holds except on frame_tick.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = serve_cnt;
    dir_x_nxt = dir_x;
    dir_y_nxt = dir_y;
    bx_nxt    = ball_x;
    by_nxt    = ball_y;
    py_nxt    = paddle_y;
    miss_nxt  = miss_count;
    if (frame_tick) begin
      if (up_sync[1] && !dn_sync[1]) begin
        py_nxt = (py >= P_SPD) ? PW'(py - P_SPD) : '0;
      end else if (dn_sync[1] && !up_sync[1]) begin
        py_nxt = (py + P_SPD >= PY_MAX) ? PW'(PY_MAX) : PW'(py + P_SPD);
      end
      unique case (state)
        ST_SERVE: begin
          bx_nxt    = BX0;
          by_nxt    = BY0;
          dir_x_nxt = 1'b0;
          if (serve_cnt == CNT_LAST || srv_sync[1]) begin
            state_nxt = ST_PLAY;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = serve_cnt + CNT_W'(1);
          end
        end
        ST_PLAY: begin
          if (dir_x) begin
            if (bx + B_SPD >= X_MAX) begin
              bx_nxt    = PW'(X_MAX);
              dir_x_nxt = 1'b0;
            end else begin
              bx_nxt = PW'(bx + B_SPD);
            end
          end else if (bx >= FACE + B_SPD) begin
            bx_nxt = PW'(bx - B_SPD);
          end else if (bx >= FACE && overlap_c) begin
            bx_nxt    = PW'(FACE);
            dir_x_nxt = 1'b1;
          end else if (bx < B_SPD) begin
            state_nxt = ST_MISS;
          end else begin
            bx_nxt = PW'(bx - B_SPD);
          end
          if (dir_y) begin
            if (by + B_SPD >= Y_MAX) begin
              by_nxt    = PW'(Y_MAX);
              dir_y_nxt = 1'b0;
            end else begin
              by_nxt = PW'(by + B_SPD);
            end
          end else if (by <= B_SPD) begin
            by_nxt    = '0;
            dir_y_nxt = 1'b1;
          end else begin
            by_nxt = PW'(by - B_SPD);
          end
        end
        ST_MISS: begin
          if (miss_count != 8'hFF) miss_nxt = miss_count + 8'd1;
          state_nxt = ST_SERVE;
          bx_nxt    = BX0;
          by_nxt    = BY0;
          dir_x_nxt = 1'b0;
        end
        default: state_nxt = ST_SERVE;
      endcase
    end
  end

  always_ff @(posedge pix_clk or negedge rst_pix_n) begin
    if (!rst_pix_n) begin
      up_sync     <= '0;
      dn_sync     <= '0;
      srv_sync    <= '0;
      frame_tick  <= 1'b0;
      state       <= ST_SERVE;
      serve_cnt   <= '0;
      dir_x       <= 1'b0;
      dir_y       <= 1'b1;
      ball_x      <= BX0;
      ball_y      <= BY0;
      paddle_y    <= PY0;
      miss_count  <= '0;
      playing     <= 1'b0;
      draw_ball   <= 1'b0;
      draw_paddle <= 1'b0;
    end else begin
      up_sync     <= {up_sync[0], btn_up};
      dn_sync     <= {dn_sync[0], btn_dn};
      srv_sync    <= {srv_sync[0], btn_serve};
      frame_tick  <= (sx == '0) && (sy == PW'(V_RES));
      state       <= state_nxt;
      serve_cnt   <= cnt_nxt;
      dir_x       <= dir_x_nxt;
      dir_y       <= dir_y_nxt;
      ball_x      <= bx_nxt;
      ball_y      <= by_nxt;
      paddle_y    <= py_nxt;
      miss_count  <= miss_nxt;
      playing     <= (state_nxt == ST_PLAY);
      draw_ball   <= in_ball_c;
      draw_paddle <= in_paddle_c;
    end
  end

endmodule
